rgmii_inband_status: RTL
========================

// Module: rgmii_inband_status
// PURPOSE
//   Decodes RGMII in-band PHY status (link, speed, duplex) from the GMII receive bus during inter-frame gaps.
//   Sits directly downstream of the RGMII PHY interface receive path, in the gmii_rx_clk domain.
//   Filters raw samples, then presents qualified status. link_speed drives that interface's speed input and MAC speed select.
// PARAMETERS
//   FILTER_LEN      default 8      consecutive identical valid samples required to commit a status (1..255)
//   TIMEOUT_CYCLES  default 65536  cycles with no valid sample before forcing link down; 0 disables timeout
//   COUNT_WIDTH     default 16     width of link_down_count
// PORTS
//   clk              in   1   receive clock (gmii_rx_clk from the PHY interface)
//   rst_n            in   1   asynchronous, active-low reset
//   gmii_rxd         in   8   receive data from PHY interface
//   gmii_rx_dv       in   1   receive data valid
//   gmii_rx_er       in   1   receive error
//   link_up          out  1   qualified link status
//   link_speed       out  2   qualified speed: 2'b10 1G, 2'b01 100M, 2'b00 10M
//   full_duplex      out  1   qualified duplex: 1 = full
//   status_valid     out  1   high once any status has been committed since reset
//   status_change    out  1   one-cycle pulse when any of link_up/link_speed/full_duplex changes
//   link_down_count  out  COUNT_WIDTH  saturating count of link_up 1->0 transitions
// BEHAVIOUR
//   Reset (rst_n low, async): all outputs 0; candidate=0, match_cnt=0, idle_cnt=0.
//   Valid sample: gmii_rx_dv==0 && gmii_rx_er==0 && gmii_rxd[3:0]==gmii_rxd[7:4] && gmii_rxd[2:1]!=2'b11.
//     Fields: link=rxd[0], speed=rxd[2:1], duplex=rxd[3]. Nibble-mismatch or reserved speed 2'b11 -> not valid.
//     rx_dv=0/rx_er=1 (false carrier, carrier extend) -> not valid.
//   Filter: 4-bit candidate {duplex,speed,link}, 8-bit match_cnt.
//     Valid && sample==candidate: match_cnt increments, saturating at FILTER_LEN.
//     Valid && sample!=candidate: candidate<=sample, match_cnt<=1.
//     Non-valid cycles (frames, errors): candidate and match_cnt hold; frames do not break a run.
//   Commit: on the edge where match_cnt reaches FILTER_LEN (or is already there) and
//     candidate differs from outputs or status_valid==0:
//     outputs <= candidate, status_valid<=1, status_change<=1 for exactly one cycle.
//     Outputs update on the edge capturing the FILTER_LEN-th matching sample (registered, 1-cycle latency).
//     FILTER_LEN==1: every differing valid sample commits immediately.
//   First commit after reset always pulses status_change, even if equal to reset values.
//   Timeout (TIMEOUT_CYCLES>0): idle_cnt counts cycles without a valid sample and clears on a valid sample.
//     On reaching TIMEOUT_CYCLES: link_up<=0 (speed/duplex hold), match_cnt<=0, idle_cnt<=0.
//     status_change pulses only if link_up was 1; status_valid unchanged.
//   Simultaneous timeout and valid sample: valid sample wins; idle_cnt clears, no timeout.
//   link_down_count increments on every link_up 1->0 (decoded or timeout); saturates at all ones, never wraps.
//   Reset asserted mid-run: immediate return to reset state; no status_change pulse emitted.
// TESTING
//   1) Reset, then 8 idle cycles rxd=8'hDD (link 1, 1G, full).
//      -> after 8th edge: link_up=1, link_speed=2'b10, full_duplex=1, status_valid=1, one status_change pulse.
//   2) From state 1, apply 7 samples 8'h33 (link 1, 100M, half), then 1 sample 8'hDD, then 8'h33 x8.
//      -> no change until 8th consecutive 8'h33: link_speed=2'b01, full_duplex=0, single pulse.
//   3) Mid-run of 5 matching 8'h11 samples, insert 200-cycle frame (rx_dv=1, random data) then 3 more 8'h11.
//      -> commit at 3rd post-frame sample; frame data never decoded.
//   4) Feed 8'hD5, 8'h77 (speed 11), rx_dv=0/rx_er=1 cycles, interleaved with a FILTER_LEN run.
//      -> all ignored; run count not reset.
//   5) TIMEOUT_CYCLES=100, link up, then hold rx_dv=1 for 100 cycles.
//      -> link_up=0 on 100th cycle, status_change pulse, link_down_count=1; speed held.
//   6) COUNT_WIDTH=2: toggle link up/down 5 times -> link_down_count saturates at 2'b11.
//      Assert rst_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rgmii_inband_status.sv
// Purpose: qualify RGMII in-band PHY status (link/speed/duplex) sampled from rxd during inter-frame gaps.
// Latency: outputs register on the edge that captures the FILTER_LEN-th matching sample (1 cycle).
// Backpressure: none; pure observer of the receive bus, every cycle is consumed.
//
// Ports:
//   clk, rst_n                 receive clock, asynchronous active-low reset
//   gmii_rxd/rx_dv/rx_er       receive bus from the RGMII PHY interface
//   link_up/link_speed/full_duplex   qualified status (speed 2'b10 1G, 2'b01 100M, 2'b00 10M)
//   status_valid               set by the first commit after reset
//   status_change              one-cycle pulse whenever the qualified status changes
//   link_down_count            saturating count of link_up 1->0 transitions
module rgmii_inband_status #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             gmii_rxd,
    input  logic                   gmii_rx_dv,
    input  logic                   gmii_rx_er,
    output logic                   link_up,
    output logic [1:0]             link_speed,
    output logic                   full_duplex,
    output logic                   status_valid,
    output logic                   status_change,
    output logic [COUNT_WIDTH-1:0] link_down_count
);

    // idle_cnt only ever holds 0..TIMEOUT_CYCLES-1: it clears on the cycle it would reach the limit.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [7:0]             FILT_MAX = 8'(FILTER_LEN);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam bit                     TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    logic [3:0]        candidate;
    logic [7:0]        match_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic       sample_ok;
    logic [3:0] sample;
    logic [3:0] cur_status;
    logic [7:0] match_nxt;
    logic       commit;
    logic       timeout;
    logic       cnt_room;

    // The in-band status nibble is repeated in both halves of the byte; a mismatch
    // or the reserved speed code means the sample is not a status word.
    // Frames (rx_dv) and false carrier / carrier extend (rx_er) are never decoded.
    assign sample     = gmii_rxd[3:0];
    assign sample_ok  = !gmii_rx_dv && !gmii_rx_er &&
                        (gmii_rxd[3:0] == gmii_rxd[7:4]) &&
                        (gmii_rxd[2:1] != 2'b11);
    assign cur_status = {full_duplex, link_speed, link_up};

    // Run length after this sample, saturating at FILTER_LEN. Only used on valid samples.
    always_comb begin
        match_nxt = 8'd1;
        if (sample == candidate) begin
            match_nxt = (match_cnt >= FILT_MAX) ? FILT_MAX : match_cnt + 8'd1;
        end
    end

    // A saturated run keeps re-qualifying; it only commits when it says something
    // new, or when nothing has been committed yet since reset.
    assign commit   = sample_ok && (match_nxt == FILT_MAX) &&
                      ((sample != cur_status) || !status_valid);

    // A valid sample on the same cycle as the limit always wins over the timeout.
    assign timeout  = TIMEOUT_EN && !sample_ok && (idle_cnt == IDLE_LAST);

    assign cnt_room = (link_down_count != CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate       <= '0;
            match_cnt       <= '0;
            idle_cnt        <= '0;
            link_up         <= 1'b0;
            link_speed      <= 2'b00;
            full_duplex     <= 1'b0;
            status_valid    <= 1'b0;
            status_change   <= 1'b0;
            link_down_count <= '0;
        end else begin
            status_change <= 1'b0;

            // Filter and idle tracking. Non-valid cycles leave the run intact so
            // that a frame in the middle of a status run does not restart it.
            if (sample_ok) begin
                candidate <= sample;
                match_cnt <= match_nxt;
                idle_cnt  <= '0;
            end else if (timeout) begin
                match_cnt <= '0;
                idle_cnt  <= '0;
            end else if (TIMEOUT_EN) begin
                idle_cnt  <= idle_cnt + 1'b1;
            end

            // Qualified status update. commit and timeout are mutually exclusive
            // because commit needs a valid sample and timeout needs its absence.
            if (commit) begin
                link_up       <= sample[0];
                link_speed    <= sample[2:1];
                full_duplex   <= sample[3];
                status_valid  <= 1'b1;
                status_change <= 1'b1;
                if (link_up && !sample[0] && cnt_room) begin
                    link_down_count <= link_down_count + 1'b1;
                end
            end else if (timeout) begin
                // Speed and duplex hold their last qualified values.
                link_up <= 1'b0;
                if (link_up) begin
                    status_change <= 1'b1;
                    if (cnt_room) begin
                        link_down_count <= link_down_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule
